// File: rtl/minimig_autoconfig_ctrl_if.sv
// Minimig autoconfig CPU-side bus: level request held until a one-cycle ack.
interface minimig_autoconfig_ctrl_if;
  logic        req;
  logic        wr;
  logic [5:0]  addr;
  logic [15:0] wdata;
  logic        ack;
  logic [15:0] rdata;

  modport master (output req, wr, addr, wdata, input ack, rdata);
  modport slave  (input req, wr, addr, wdata, output ack, rdata);
endinterface

// File: rtl/minimig_autoconfig_ctrl.sv
// Minimig autoconfig sequencer: walks the board slots of the autoconfig nibble ROM,
// serves $E80000 window reads from the current slot and latches CPU-written bases.
// Optional macro MINIMIG_AUTOCONFIG_SHUTUP_EN: when defined, a write to offset 0x4C
// retires the current board unconfigured; otherwise it is acked and ignored.
module minimig_autoconfig_ctrl #(
  parameter int unsigned NSLOTS  = 7,
  parameter logic [6:0]  Z2_MASK = 7'b1100001
) (
  input  logic                            clk,
  input  logic                            reset,
  minimig_autoconfig_ctrl_if.slave        bus,
  input  logic [6:0]                      board_en,
  input  logic [1:0]                      fastram_size,
  output logic [8:0]                      rom_a_read,
  input  logic [3:0]                      rom_q,
  output logic [8:0]                      rom_a_write,
  output logic [3:0]                      rom_d,
  output logic                            rom_we,
  output logic                            cfg_done,
  input  logic [2:0]                      base_sel,
  output logic [15:0]                     base_out,
  output logic [6:0]                      slot_cfg
);

  typedef enum logic [2:0] {StInit, StSeek, StIdle, StRead, StAck, StDone} state_e;

  state_e      state_q;
  logic [2:0]  slot_q;
  logic [2:0]  ptr_q;
  logic [1:0]  rd_cnt_q;
  logic [6:0]  en_q;
  logic [6:0]  slot_cfg_q;
  logic [15:0] base_q [8];
  logic [3:0]  size_nib;
  logic        is_z2;

  // Size nibble written into the Z2 Fast RAM board's er_Type register.
  always_comb begin
    size_nib = 4'b0000;
    case (fastram_size)
      2'b01:   size_nib = 4'b0110;
      2'b10:   size_nib = 4'b0111;
      default: size_nib = 4'b0000;
    endcase
  end

  assign is_z2    = ({1'b0, Z2_MASK} >> slot_q) & 8'h01 ? 1'b1 : 1'b0;
  assign base_out = base_q[base_sel];
  assign slot_cfg = slot_cfg_q;

  // Sequencer: init ROM patch, slot search, bus servicing; all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StInit;
      slot_q      <= 3'd0;
      ptr_q       <= 3'd0;
      rd_cnt_q    <= 2'd0;
      en_q        <= 7'd0;
      slot_cfg_q  <= 7'd0;
      for (int i = 0; i < 8; i++) base_q[i] <= 16'h0000;
      bus.ack     <= 1'b0;
      bus.rdata   <= 16'hFFFF;
      rom_a_read  <= 9'd0;
      rom_a_write <= 9'd0;
      rom_d       <= 4'd0;
      rom_we      <= 1'b0;
      cfg_done    <= 1'b0;
    end else begin
      bus.ack <= 1'b0;
      rom_we  <= 1'b0;
      case (state_q)
        StInit: begin
          // No Fast RAM: hide the Z2 RAM board instead of advertising size 0.
          en_q  <= {board_en[6:1], board_en[0] & (fastram_size != 2'b00)};
          if (fastram_size != 2'b00) begin
            rom_we      <= 1'b1;
            rom_a_write <= 9'h001;
            rom_d       <= size_nib;
          end
          ptr_q   <= 3'd0;
          state_q <= StSeek;
        end
        StSeek: begin
          if (ptr_q >= 3'(NSLOTS)) begin
            slot_q   <= 3'd7;
            cfg_done <= 1'b1;
            state_q  <= StDone;
          end else if (en_q[ptr_q]) begin
            slot_q  <= ptr_q;
            state_q <= StIdle;
          end else begin
            ptr_q <= ptr_q + 3'd1;
          end
        end
        StIdle: begin
          if (bus.req && !bus.wr) begin
            rom_a_read <= {slot_q, bus.addr};
            rd_cnt_q   <= 2'd0;
            state_q    <= StRead;
          end else if (bus.req) begin
            bus.ack <= 1'b1;
            state_q <= StAck;
            if (bus.addr == 6'h22 && !is_z2) begin
              base_q[slot_q]     <= bus.wdata;
              slot_cfg_q[slot_q] <= 1'b1;
              ptr_q              <= slot_q + 3'd1;
              state_q            <= StSeek;
            end else if (bus.addr == 6'h24 && is_z2) begin
              base_q[slot_q]     <= {8'h00, bus.wdata[15:8]};
              slot_cfg_q[slot_q] <= 1'b1;
              ptr_q              <= slot_q + 3'd1;
              state_q            <= StSeek;
            end
`ifdef MINIMIG_AUTOCONFIG_SHUTUP_EN
            else if (bus.addr == 6'h26) begin
              ptr_q   <= slot_q + 3'd1;
              state_q <= StSeek;
            end
`endif
          end
        end
        StRead: begin
          // ROM data is valid two edges after the address; capture on the third.
          rd_cnt_q <= rd_cnt_q + 2'd1;
          if (rd_cnt_q == 2'd2) begin
            bus.rdata <= {rom_q, 12'hFFF};
            bus.ack   <= 1'b1;
            state_q   <= StAck;
          end
        end
        StAck: begin
          // Ack cycle: keeps the still-held req from being accepted twice.
          state_q <= StIdle;
        end
        StDone: begin
          if (bus.req && !bus.ack) begin
            bus.ack <= 1'b1;
            if (!bus.wr) bus.rdata <= 16'hFFFF;
          end
        end
        default: state_q <= StInit;
      endcase
    end
  end

endmodule

// File: doc/minimig_autoconfig_ctrl.md
Name: minimig_autoconfig_ctrl

Overview:
- Sequencer directly downstream of the autoconfig nibble ROM.
- Walks the ROM's seven board slots in order and serves CPU reads in the $E80000 autoconfig window from the current slot.
- Latches the base addresses the CPU writes and advances to the next enabled board, so each board appears in turn.
- At reset release it writes the Zorro-II Fast RAM size nibble into the ROM.

Parameters:
- NSLOTS, 7, number of real board slots (slot 7 is the null terminator).
- Z2_MASK, 7'b1100001, slots decoded as Zorro-II (bit set) versus Zorro-III (bit clear).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous reset, active-high
- board_en  in  7  slot enable mask, sampled in INIT
- fastram_size  in  2  Z2 Fast RAM size: 00 none, 01 2MB, 10 4MB, 11 8MB
- req  in  1  CPU access request, level, held until ack
- wr  in  1  1 = write, 0 = read
- addr  in  6  register offset/2, i.e. A6..A1
- wdata  in  16  write data
- ack  out  1  one-cycle completion pulse
- rdata  out  16  read data, {nibble, 12'hFFF}
- rom_a_read  out  9  ROM read address, {slot, addr}
- rom_q  in  4  ROM data, valid 2 cycles after rom_a_read
- rom_a_write  out  9  ROM write address
- rom_d  out  4  ROM write data
- rom_we  out  1  ROM write strobe
- cfg_done  out  1  chain exhausted
- base_sel  in  3  slot selected for base readback
- base_out  out  16  A31..A16 base of the selected slot; Z2 slots return {8'h00, A23..A16}
- slot_cfg  out  7  per-slot configured flag

Behaviour:
- Reset values: ack=0, rdata=16'hFFFF, rom_a_read=0, rom_a_write=0, rom_d=0, rom_we=0, cfg_done=0, slot_cfg=0, all bases 0, slot=0, state=INIT.
- Reset asserted mid-operation aborts any pending access and ROM write; no ack is issued.

- INIT (1 cycle):
  - Latch board_en.
  - If fastram_size != 00: rom_we=1, rom_a_write=9'h001, rom_d = 0110, 0111 or 0000 for 2MB, 4MB or 8MB.
  - If fastram_size = 00: clear latched enable bit 0 and do not write.
  - Go to SEEK with a scan pointer of 0.

- SEEK:
  - Examines one slot per cycle starting at the scan pointer.
  - On the first enabled slot: slot := it, go to IDLE.
  - If the pointer passes slot 6: slot := 7, cfg_done := 1, go to DONE.

- IDLE, read accepted (req & ~wr), on edge N:
  - rom_a_read <= {slot, addr}.
  - ROM output is valid after edge N+2.
  - Edge N+3: rdata <= {rom_q, 12'hFFF}, ack=1 for one cycle.
  - Back to IDLE; the next req is accepted no earlier than the cycle after ack.

- IDLE, write accepted; ack is issued on the next cycle in every case:
  - offset 0x44 (addr=6'h22) on a Z3 slot: base[slot] := wdata, slot_cfg[slot] := 1, advance.
  - offset 0x48 (addr=6'h24) on a Z2 slot: base[slot] := {8'h00, wdata[15:8]}, slot_cfg[slot] := 1, advance.
  - offset 0x48 on a Z3 slot: ignored.
  - offset 0x4C (addr=6'h26): shut-up. Base stays 0, slot_cfg stays 0, advance.
  - Any other offset: ignored.

- Advance: scan pointer := slot+1, then SEEK.
- req arriving during INIT or SEEK waits, because req is held, until IDLE.
- DONE:
  - Reads ack 1 cycle after req with rdata=16'hFFFF.
  - Writes are acked 1 cycle after req and ignored.
  - Only reset leaves DONE.
- base_out and slot_cfg are combinational from registers.

Optional Feature:
- Macro: MINIMIG_AUTOCONFIG_SHUTUP_EN.
- Defined: 0x4C writes behave as shut-up, as described above.
- Undefined: 0x4C writes are acked and ignored; the board stays current until a base is written.

Test Plan:
- board_en=7'h7F, fastram_size=11: after reset, one rom_we with rom_a_write=9'h001, rom_d=0000; state reaches IDLE with slot=0.
- Read addr=6'h08 (offset 0x10) in slot 0: rom_a_read=9'h008 the cycle after req sampled; ack 3 cycles after acceptance; rdata=16'hEFFF given rom_q=4'hE.
- Write addr=6'h24, wdata=16'h2000 on slot 0: ack next cycle; slot_cfg[0]=1; base_sel=0 gives base_out=16'h0020; slot becomes 1.
- Slot 1 (Z3): write addr=6'h24 is ignored; then write addr=6'h22, wdata=16'h4000 gives base_out=16'h4000, slot_cfg[1]=1.
- board_en=7'b0000101, fastram_size=00: slot 0 is skipped and slot 2 is current; a shut-up at 0x4C gives cfg_done=1, and a subsequent read returns rdata=16'hFFFF.
- Assert reset 1 cycle after a read is accepted: no ack; all outputs return to reset values; the INIT ROM write repeats.
